game_reporter: RTL and testbench
================================

GAME_REPORTER -- requirements
Module: game_reporter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event queue depth in entries (power of two, 2..16).
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge clocked.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 ev_valid  input  1  SHALL mark a game event on this cycle.
REQ-005 ev_code  input  4  SHALL carry the command code: 1 LEFT, 2 RIGHT, 3 DOWN, 4 DROP, 5 HOLD, 6 ROTATE, 7 ROTATE_REV, 0 NONE.
REQ-006 score  input  16  SHALL carry the current score, sampled with the event.
REQ-007 is_transmitting  input  1  SHALL carry the UART byte-transmitter busy flag.
REQ-008 transmit  output  1  SHALL be a one-cycle start pulse to the UART byte transmitter.
REQ-009 tx_byte  output  8  SHALL carry the byte to send; valid while transmit=1.
REQ-010 ev_ready  output  1  SHALL be 1 when the queue is not full.
REQ-011 busy  output  1  SHALL be 1 when a frame is in progress or the queue is non-empty.
REQ-012 drop_cnt  output  8  SHALL count events lost to a full queue.

Function
REQ-013 An event SHALL be enqueued as {ev_code, score} when ev_valid=1, ev_code!=0 and the queue is not full.
- ev_code=0 is ignored; it is neither queued nor counted.
REQ-014 An event with ev_valid=1, ev_code!=0 and the queue full SHALL be discarded; drop_cnt increments and saturates at 255.
REQ-015 Each queued event SHALL produce one 8-byte frame: letter, ':', four uppercase hex digits of score (MSB nibble first), 0x0D, 0x0A.
REQ-016 Letter mapping SHALL be 1 'L', 2 'R', 3 'D', 4 'S', 5 'C', 6 'X', 7 'Z'; codes 8..15 SHALL map to '?'.
REQ-017 States SHALL be IDLE, LOAD, SEND, ARM, DRAIN.
REQ-018 IDLE -> LOAD when the queue is non-empty and is_transmitting=0.
REQ-019 LOAD SHALL pop the head entry into a frame register, clear the byte index, then go to SEND.
REQ-020 SEND SHALL assert transmit for exactly one cycle with tx_byte = frame byte[index], then go to ARM.
REQ-021 ARM SHALL last one cycle to absorb transmitter latency, then go to DRAIN.
REQ-022 DRAIN SHALL wait for is_transmitting=0.
- index<7: increment index, go to SEND.
- index=7: go to LOAD if the queue is non-empty, else IDLE.
REQ-023 transmit SHALL never be asserted outside SEND; tx_byte SHALL hold its last value otherwise.
REQ-024 Simultaneous enqueue and pop on a full queue SHALL accept the new event (pop frees the slot); the occupancy count is unchanged.
REQ-025 Queue pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-026 The score SHALL be taken from the queue entry, never from the live score input, during the frame.
REQ-027 Minimum spacing between transmit pulses SHALL be 3 cycles.

Reset
REQ-028 With reset_n=0 at a clock edge, the block SHALL go to IDLE and set:
- queue empty, index 0;
- transmit=0, tx_byte=0x00, drop_cnt=0;
- ev_ready=1, busy=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; no further transmit pulse is issued and queued events are discarded.

Verification
REQ-030 Single event: code 2, score 0x1A2F, UART model busy 10 cycles per byte -> bytes 'R' ':' '1' 'A' '2' 'F' 0x0D 0x0A, 8 transmit pulses, busy returns to 0.
REQ-031 Overflow: FIFO_DEPTH=4, 6 back-to-back events while is_transmitting is held 1 -> 4 accepted, drop_cnt=2, ev_ready=0 after the fourth event.
REQ-032 Ordering: events (1,0x0001), (7,0xFFFF) -> frames "L:0001\r\n" then "Z:FFFF\r\n", with no interleaving.
REQ-033 Score isolation: enqueue (3,0x00AB), then change score to 0x1234 during the frame -> frame "D:00AB\r\n".
REQ-034 Filtering: ev_code 0 -> no frame and drop_cnt unchanged; ev_code 9 -> frame starting '?'.
REQ-035 Reset at byte 3 of a frame -> transmit stays 0 afterwards; drop_cnt=0, busy=0, ev_ready=1.

Source files
------------

// File: rtl/game_reporter_if.sv
// Event-in / UART-byte-out bundle for the game reporter.
// The slave modport is the reporter's view; the master modport is the producer/UART side.
interface game_reporter_if;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic [15:0] score;
  logic        ev_ready;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;

  modport slave (
    input  ev_valid, ev_code, score, is_transmitting,
    output ev_ready, busy, drop_cnt, transmit, tx_byte
  );

  modport master (
    output ev_valid, ev_code, score, is_transmitting,
    input  ev_ready, busy, drop_cnt, transmit, tx_byte
  );
endinterface

// File: rtl/game_reporter.sv
// Queues game events and serialises each one as an 8-byte ASCII frame
// ("<letter>:HHHH\r\n") through a byte-wide UART transmitter.
module game_reporter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  game_reporter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, ARM, DRAIN} state_t;

  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [19:0]   frame_reg;
  logic [2:0]    index_reg;
  logic          transmit_reg;
  logic [7:0]    tx_byte_reg;
  logic [7:0]    drop_cnt_reg;
  state_t        state_reg;

  logic full, empty, pop, accept, push, drop;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] letter(input logic [3:0] code);
    case (code)
      4'd1:    return 8'h4C; // L
      4'd2:    return 8'h52; // R
      4'd3:    return 8'h44; // D
      4'd4:    return 8'h53; // S
      4'd5:    return 8'h43; // C
      4'd6:    return 8'h58; // X
      4'd7:    return 8'h5A; // Z
      default: return 8'h3F; // ?
    endcase
  endfunction

  // Entry layout is {code[19:16], score[15:0]}.
  function automatic logic [7:0] frame_byte(input logic [19:0] entry, input logic [2:0] idx);
    case (idx)
      3'd0:    return letter(entry[19:16]);
      3'd1:    return 8'h3A;
      3'd2:    return hex_digit(entry[15:12]);
      3'd3:    return hex_digit(entry[11:8]);
      3'd4:    return hex_digit(entry[7:4]);
      3'd5:    return hex_digit(entry[3:0]);
      3'd6:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign full   = (count_reg == CW'(FIFO_DEPTH));
  assign empty  = (count_reg == '0);
  assign pop    = (state_reg == LOAD) && !empty;
  assign accept = bus.ev_valid && (bus.ev_code != 4'd0);
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.ev_code, bus.score};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      frame_reg    <= '0;
      index_reg    <= '0;
      transmit_reg <= 1'b0;
      tx_byte_reg  <= 8'h00;
      drop_cnt_reg <= 8'h00;
      state_reg    <= IDLE;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 1'b1;

      transmit_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!empty && !bus.is_transmitting) state_reg <= LOAD;
        end
        LOAD: begin
          if (empty) begin
            state_reg <= IDLE;
          end else begin
            // Outputs are registered, so the first byte is launched here to
            // be visible during the SEND cycle.
            frame_reg    <= fifo_mem[rd_ptr_reg];
            index_reg    <= 3'd0;
            transmit_reg <= 1'b1;
            tx_byte_reg  <= frame_byte(fifo_mem[rd_ptr_reg], 3'd0);
            state_reg    <= SEND;
          end
        end
        SEND:  state_reg <= ARM;
        ARM:   state_reg <= DRAIN;
        DRAIN: begin
          if (!bus.is_transmitting) begin
            if (index_reg != 3'd7) begin
              index_reg    <= index_reg + 3'd1;
              transmit_reg <= 1'b1;
              tx_byte_reg  <= frame_byte(frame_reg, index_reg + 3'd1);
              state_reg    <= SEND;
            end else begin
              state_reg <= empty ? IDLE : LOAD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.transmit = transmit_reg;
  assign bus.tx_byte  = tx_byte_reg;
  assign bus.drop_cnt = drop_cnt_reg;
  assign bus.ev_ready = !full;
  assign bus.busy     = (state_reg != IDLE) || !empty;
endmodule

// File: tb/tb_game_reporter.sv
// Directed bench for game_reporter: expected frame bytes are queued as
// stimulus is issued and a monitor checks every transmit pulse against them.
module tb_game_reporter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hold_tx = 1'b0;
  int   uart_cnt;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_cnt = 0;
  int   gap = 100;
  logic [7:0] exp_q[$];

  game_reporter_if bus ();

  game_reporter #(.FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each start pulse.
  always @(posedge clk) begin
    if (!reset_n)          uart_cnt <= 0;
    else if (bus.transmit) uart_cnt <= 10;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign bus.is_transmitting = hold_tx | (uart_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transmit pulse must match the next expected byte.
  always @(negedge clk) begin
    if (!reset_n) begin
      gap = 100;
    end else begin
      gap++;
      if (bus.transmit) begin
        pulse_cnt++;
        check("tx_gap_ge3", 32'(gap >= 3), 32'd1);
        gap = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte 0x%02h, expected no transmit", bus.tx_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_byte), 32'(e));
          $display("tx byte 0x%02h (expected 0x%02h)", bus.tx_byte, e);
        end
      end
    end
  end

  task automatic push_frame(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_ev(input logic [3:0] code, input logic [15:0] sc);
    @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_code  = code;
    bus.score    = sc;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    bus.ev_code  = 4'd0;
    $display("event code=%0d score=0x%04h", code, sc);
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int k;
    for (k = 0; k < max_cycles; k++) begin
      @(posedge clk); #1;
      if (!bus.busy) break;
    end
    if (k == max_cycles) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, max_cycles);
    end
    check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pulses(input int target, input int max_cycles);
    int k;
    for (k = 0; k < max_cycles; k++) begin
      @(posedge clk); #1;
      if (pulse_cnt >= target) break;
    end
    if (k == max_cycles) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_wait_timeout: got %0d pulses, expected %0d", pulse_cnt, target);
    end
  endtask

  initial begin
    int base;
    bus.ev_valid = 1'b0;
    bus.ev_code  = 4'd0;
    bus.score    = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_transmit", 32'(bus.transmit), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_ev_ready", 32'(bus.ev_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single event
    base = pulse_cnt;
    push_frame("R:1A2F");
    send_ev(4'd2, 16'h1A2F);
    wait_idle("single", 400);
    check("single_pulses", 32'(pulse_cnt - base), 32'd8);

    // Ordering
    push_frame("L:0001");
    push_frame("Z:FFFF");
    send_ev(4'd1, 16'h0001);
    send_ev(4'd7, 16'hFFFF);
    wait_idle("order", 800);

    // Score isolation
    push_frame("D:00AB");
    send_ev(4'd3, 16'h00AB);
    bus.score = 16'h1234;
    wait_idle("isolation", 400);

    // Filtering: code 0 ignored, code 9 maps to '?'
    base = pulse_cnt;
    send_ev(4'd0, 16'h5555);
    repeat (30) @(posedge clk);
    #1;
    check("code0_busy", 32'(bus.busy), 32'd0);
    check("code0_no_tx", 32'(pulse_cnt - base), 32'd0);
    check("code0_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    push_frame("?:0000");
    send_ev(4'd9, 16'h0000);
    wait_idle("code9", 400);

    // Overflow: 6 back-to-back events with the transmitter held busy
    hold_tx = 1'b1;
    push_frame("L:0000");
    push_frame("R:1111");
    push_frame("D:2222");
    push_frame("S:3333");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) check("ovf_ready_after3", 32'(bus.ev_ready), 32'd1);
      if (i == 4) check("ovf_ready_after4", 32'(bus.ev_ready), 32'd0);
      bus.ev_valid = 1'b1;
      bus.ev_code  = 4'(i + 1);
      bus.score    = 16'(i * 16'h1111);
    end
    @(negedge clk);
    bus.ev_valid = 1'b0;
    bus.ev_code  = 4'd0;
    check("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    check("ovf_busy", 32'(bus.busy), 32'd1);
    hold_tx = 1'b0;
    wait_idle("overflow", 1600);

    // Reset mid-frame, with a second event still queued
    base = pulse_cnt;
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h42);
    send_ev(4'd4, 16'hBEEF);
    send_ev(4'd5, 16'h0042);
    wait_pulses(base + 3, 200);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("midrst_no_tx", 32'(pulse_cnt - base), 32'd3);
    check("midrst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ev_ready", 32'(bus.ev_ready), 32'd1);
    check("midrst_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
